// File: rtl/rf_param_if.sv
// Register file access bundle: two combinational read ports and two byte-masked write ports.
// master: decode/writeback side, drives addresses and write data, receives read data.
// slave:  register file side.
interface rf_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0]   regRNum1;
  logic [ADDR_W-1:0]   regRNum2;
  logic [DATA_W-1:0]   rData1;
  logic [DATA_W-1:0]   rData2;

  logic [ADDR_W-1:0]   wReg0;
  logic [DATA_W-1:0]   data0;
  logic                RegWrite0;
  logic [DATA_W/8-1:0] byteEn0;

  logic [ADDR_W-1:0]   wReg1;
  logic [DATA_W-1:0]   data1;
  logic                RegWrite1;
  logic [DATA_W/8-1:0] byteEn1;

  modport master (
    output regRNum1, regRNum2,
    output wReg0, data0, RegWrite0, byteEn0,
    output wReg1, data1, RegWrite1, byteEn1,
    input  rData1, rData2
  );

  modport slave (
    input  regRNum1, regRNum2,
    input  wReg0, data0, RegWrite0, byteEn0,
    input  wReg1, data1, RegWrite1, byteEn1,
    output rData1, rData2
  );
endinterface

// File: rtl/rf_param.sv
// Parametrised register file: 2**ADDR_W registers of DATA_W bits, two write ports with
// per-byte enables (port 1 wins per lane on a same-address collision), two combinational
// read ports, optional hardwired zero register and optional write-to-read forwarding.
// Ports:
//   clk   - rising-edge write clock
//   reset - asynchronous active-low clear; also forces both read ports to zero
//   bus   - rf_param_if slave: read addresses/data, write port 0 (ALU), port 1 (load)
module rf_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 0
) (
  input logic    clk,
  input logic    reset,
  rf_param_if.slave bus
);
  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned Lanes = DATA_W / 8;

  if ((DATA_W % 8) != 0 || DATA_W == 0) begin : gen_width_check
    $error("rf_param: DATA_W (%0d) must be a non-zero multiple of 8", DATA_W);
  end

  // Bit-level write masks; zero whenever the port is disabled, so a disabled port's
  // address and data never reach storage or the forwarding path.
  logic [DATA_W-1:0] mask0;
  logic [DATA_W-1:0] mask1;

  for (genvar l = 0; l < Lanes; l++) begin : gen_lane
    assign mask0[l*8 +: 8] = {8{bus.RegWrite0 & bus.byteEn0[l]}};
    assign mask1[l*8 +: 8] = {8{bus.RegWrite1 & bus.byteEn1[l]}};
  end

  // regsQ: stored contents; regsD: contents after the coming edge (also the bypass value).
  logic [DATA_W-1:0] regsQ [Depth];
  logic [DATA_W-1:0] regsD [Depth];

  for (genvar a = 0; a < Depth; a++) begin : gen_reg
    if (ZERO_REG != 0 && a == 0) begin : gen_zero
      assign regsQ[a] = '0;
      assign regsD[a] = '0;
    end else begin : gen_store
      logic [DATA_W-1:0] regQ;
      logic [DATA_W-1:0] regD;
      logic              hit0;
      logic              hit1;

      assign hit0 = (bus.wReg0 == ADDR_W'(a));
      assign hit1 = (bus.wReg1 == ADDR_W'(a));

      // Port 1 merged last so it takes lanes enabled on both ports.
      always_comb begin
        regD = regQ;
        if (hit0) regD = (regD & ~mask0) | (bus.data0 & mask0);
        if (hit1) regD = (regD & ~mask1) | (bus.data1 & mask1);
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          regQ <= '0;
        end else begin
          regQ <= regD;
        end
      end

      assign regsQ[a] = regQ;
      assign regsD[a] = regD;
    end
  end

  always_comb begin
    bus.rData1 = '0;
    bus.rData2 = '0;
    if (reset) begin
      if (BYPASS != 0) begin
        bus.rData1 = regsD[bus.regRNum1];
        bus.rData2 = regsD[bus.regRNum2];
      end else begin
        bus.rData1 = regsQ[bus.regRNum1];
        bus.rData2 = regsQ[bus.regRNum2];
      end
    end
  end
endmodule

// File: tb/tb_rf_param.sv
// Bench for rf_param. Three instances: A (32x32, zero reg, no bypass), B (32x32, no zero reg,
// bypass) sharing one stimulus, and C (8x16, no zero reg, no bypass) with its own stimulus.
// A per-address array model predicts every read port on every falling edge; directed
// literal expectations pin the model at key points.
module tb_rf_param;
  logic clk;
  logic rst_n;

  // Shared stimulus for A/B
  logic [4:0]  ra1, ra2, w0a, w1a;
  logic [31:0] d0, d1;
  logic        we0, we1;
  logic [3:0]  be0, be1;
  // Stimulus for C; addresses are 4 bits so address 8 can be driven and must alias to 0
  logic [3:0]  nra1, nra2, nw0a, nw1a;
  logic [15:0] nd0, nd1;
  logic        nwe0, nwe1;
  logic [1:0]  nbe0, nbe1;

  int passCount, totalCount;
  bit chkOn;

  logic [31:0] m0 [32];  // model of A
  logic [31:0] m1 [32];  // model of B
  logic [15:0] m2 [8];   // model of C

  rf_param_if #(.DATA_W(32), .ADDR_W(5)) busA ();
  rf_param_if #(.DATA_W(32), .ADDR_W(5)) busB ();
  rf_param_if #(.DATA_W(16), .ADDR_W(3)) busC ();

  assign busA.regRNum1 = ra1;  assign busB.regRNum1 = ra1;
  assign busA.regRNum2 = ra2;  assign busB.regRNum2 = ra2;
  assign busA.wReg0 = w0a;     assign busB.wReg0 = w0a;
  assign busA.data0 = d0;      assign busB.data0 = d0;
  assign busA.RegWrite0 = we0; assign busB.RegWrite0 = we0;
  assign busA.byteEn0 = be0;   assign busB.byteEn0 = be0;
  assign busA.wReg1 = w1a;     assign busB.wReg1 = w1a;
  assign busA.data1 = d1;      assign busB.data1 = d1;
  assign busA.RegWrite1 = we1; assign busB.RegWrite1 = we1;
  assign busA.byteEn1 = be1;   assign busB.byteEn1 = be1;

  assign busC.regRNum1 = nra1[2:0];
  assign busC.regRNum2 = nra2[2:0];
  assign busC.wReg0 = nw0a[2:0];
  assign busC.data0 = nd0;
  assign busC.RegWrite0 = nwe0;
  assign busC.byteEn0 = nbe0;
  assign busC.wReg1 = nw1a[2:0];
  assign busC.data1 = nd1;
  assign busC.RegWrite1 = nwe1;
  assign busC.byteEn1 = nbe1;

  rf_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dutA (
    .clk(clk), .reset(rst_n), .bus(busA.slave)
  );
  rf_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(1)) dutB (
    .clk(clk), .reset(rst_n), .bus(busB.slave)
  );
  rf_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dutC (
    .clk(clk), .reset(rst_n), .bus(busC.slave)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Value register `addr` of a 32-bit instance holds after the coming edge.
  function automatic logic [31:0] next32(input logic [31:0] cur, input int addr, input bit zr);
    logic [31:0] v;
    v = cur;
    if (zr && addr == 0) return 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (we1 && int'(w1a) == addr && be1[b]) v[b*8 +: 8] = d1[b*8 +: 8];
      else if (we0 && int'(w0a) == addr && be0[b]) v[b*8 +: 8] = d0[b*8 +: 8];
    end
    return v;
  endfunction

  function automatic logic [15:0] next16(input logic [15:0] cur, input int addr);
    logic [15:0] v;
    v = cur;
    for (int b = 0; b < 2; b++) begin
      if (nwe1 && (int'(nw1a) % 8) == addr && nbe1[b]) v[b*8 +: 8] = nd1[b*8 +: 8];
      else if (nwe0 && (int'(nw0a) % 8) == addr && nbe0[b]) v[b*8 +: 8] = nd0[b*8 +: 8];
    end
    return v;
  endfunction

  function automatic logic [31:0] exp32(input int addr, input bit zr, input bit bp);
    logic [31:0] cur;
    if (!rst_n) return 32'h0;
    if (zr && addr == 0) return 32'h0;
    cur = zr ? m0[addr] : m1[addr];
    return bp ? next32(cur, addr, zr) : cur;
  endfunction

  function automatic logic [15:0] exp16(input int addr);
    return rst_n ? m2[addr % 8] : 16'h0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < 32; a++) begin
        m0[a] <= 32'h0;
        m1[a] <= 32'h0;
      end
      for (int a = 0; a < 8; a++) m2[a] <= 16'h0;
    end else begin
      for (int a = 0; a < 32; a++) begin
        m0[a] <= next32(m0[a], a, 1'b1);
        m1[a] <= next32(m1[a], a, 1'b0);
      end
      for (int a = 0; a < 8; a++) m2[a] <= next16(m2[a], a);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chkOn) begin
      check("A.rData1", busA.rData1, exp32(int'(ra1), 1'b1, 1'b0));
      check("A.rData2", busA.rData2, exp32(int'(ra2), 1'b1, 1'b0));
      check("B.rData1", busB.rData1, exp32(int'(ra1), 1'b0, 1'b1));
      check("B.rData2", busB.rData2, exp32(int'(ra2), 1'b0, 1'b1));
      check("C.rData1", 32'(busC.rData1), 32'(exp16(int'(nra1))));
      check("C.rData2", 32'(busC.rData2), 32'(exp16(int'(nra2))));
    end
  end

  // Disabled ports carry junk to show it has no effect.
  task automatic idle();
    we0 = 1'b0; w0a = 5'($urandom); d0 = $urandom; be0 = 4'($urandom);
    we1 = 1'b0; w1a = 5'($urandom); d1 = $urandom; be1 = 4'($urandom);
  endtask

  task automatic nidle();
    nwe0 = 1'b0; nw0a = 4'($urandom); nd0 = 16'($urandom); nbe0 = 2'($urandom);
    nwe1 = 1'b0; nw1a = 4'($urandom); nd1 = 16'($urandom); nbe1 = 2'($urandom);
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    we0 = 1'b1; w0a = a; d0 = d; be0 = be;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    we1 = 1'b1; w1a = a; d1 = d; be1 = be;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    passCount = 0; totalCount = 0; chkOn = 1'b0;
    rst_n = 1'b1;
    ra1 = '0; ra2 = '0; nra1 = '0; nra2 = '0;
    idle();
    nidle();
    #1 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;  // released mid-cycle
    chkOn = 1'b1;

    // Fill reg k = k*10 and read back pairs
    for (int k = 0; k < 32; k++) begin
      wr0(5'(k), 32'(k * 10), 4'hF);
      step();
    end
    idle();
    for (int k = 0; k < 32; k++) begin
      ra1 = 5'(k);
      ra2 = 5'(k + 1);
      #1;
      check("fill.A", busA.rData1, (k == 0) ? 32'h0 : 32'(k * 10));
      check("fill.B", busB.rData1, 32'(k * 10));
      step();
    end

    // Asynchronous reset pulse between edges
    ra1 = 5'd5;
    #1;
    check("prerst.B", busB.rData1, 32'd50);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst.A", busA.rData1, 32'h0);
    check("rst.B", busB.rData1, 32'h0);
    #2 rst_n = 1'b1;
    #1;
    check("rstclr.B", busB.rData1, 32'h0);

    // Write attempted across an edge with reset held low
    step();
    rst_n = 1'b0;
    wr0(5'd7, 32'h77, 4'hF);
    ra1 = 5'd7;
    step();
    idle();
    #2 rst_n = 1'b1;
    #1;
    check("rsthold.B", busB.rData1, 32'h0);
    step();

    // Register 0
    wr0(5'd0, 32'h55, 4'hF);
    step();
    idle();
    ra1 = 5'd0;
    #1;
    check("zero.A", busA.rData1, 32'h0);
    check("zero.B", busB.rData1, 32'h55);

    // Byte enables
    wr0(5'd5, 32'h1122_3344, 4'hF);
    step();
    wr0(5'd5, 32'hAABB_CCDD, 4'b0101);
    step();
    idle();
    ra1 = 5'd5;
    #1;
    check("bytes.A", busA.rData1, 32'h11BB_33DD);
    check("bytes.B", busB.rData1, 32'h11BB_33DD);
    wr0(5'd5, 32'hFFFF_FFFF, 4'b0000);
    step();
    idle();
    #1;
    check("noLanes.A", busA.rData1, 32'h11BB_33DD);

    // Dual-write collision, per-lane port-1 priority
    wr0(5'd9, 32'h0, 4'hF);
    step();
    wr0(5'd9, 32'h0101_0101, 4'b0011);
    wr1(5'd9, 32'h0202_0202, 4'b0110);
    ra1 = 5'd9;
    #1;
    check("collFwd.B", busB.rData1, 32'h0002_0201);
    check("collPre.A", busA.rData1, 32'h0);
    step();
    idle();
    #1;
    check("coll.A", busA.rData1, 32'h0002_0201);
    check("coll.B", busB.rData1, 32'h0002_0201);

    wr0(5'd3, 32'h333, 4'hF);
    wr1(5'd4, 32'h444, 4'hF);
    step();
    idle();
    ra1 = 5'd3;
    ra2 = 5'd4;
    #1;
    check("dual.A3", busA.rData1, 32'h333);
    check("dual.A4", busA.rData2, 32'h444);

    // Collision on register 0
    wr0(5'd0, 32'hA5A5_A5A5, 4'hF);
    wr1(5'd0, 32'h5A5A_5A5A, 4'b1000);
    ra1 = 5'd0;
    #1;
    check("zeroFwd.B", busB.rData1, 32'h5AA5_A5A5);
    check("zeroFwd.A", busA.rData1, 32'h0);
    step();
    idle();

    // Forwarding
    wr0(5'd7, 32'h100, 4'hF);
    step();
    wr0(5'd7, 32'h200, 4'hF);
    ra1 = 5'd7;
    #1;
    check("fwd.A", busA.rData1, 32'h100);
    check("fwd.B", busB.rData1, 32'h200);
    step();
    idle();
    #1;
    check("fwdAfter.A", busA.rData1, 32'h200);
    wr0(5'd7, 32'h100, 4'hF);
    step();
    wr0(5'd7, 32'h200, 4'b0001);
    #1;
    check("fwdLane.A", busA.rData1, 32'h100);
    check("fwdLane.B", busB.rData1, 32'h100);
    step();
    idle();

    // 16-bit, 8-entry instance
    for (int k = 0; k < 8; k++) begin
      nwe0 = 1'b1; nw0a = 4'(k); nd0 = 16'hF0F0 + 16'(k); nbe0 = 2'b11;
      step();
    end
    nidle();
    for (int k = 0; k < 8; k++) begin
      nra1 = 4'(k);
      #1;
      check("narrow.C", 32'(busC.rData1), 32'(16'hF0F0 + 16'(k)));
      step();
    end
    nwe0 = 1'b1; nw0a = 4'd8; nd0 = 16'hBEEF; nbe0 = 2'b11;
    step();
    nidle();
    nra1 = 4'd0;
    nra2 = 4'd1;
    #1;
    check("alias.C0", 32'(busC.rData1), 32'h0000_BEEF);
    check("alias.C1", 32'(busC.rData2), 32'h0000_F0F1);
    step();
    step();

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end
endmodule

// File: doc/rf_param.md
Name: rf_param

Overview:
- Parametrised successor to the single-write, dual-read register file.
- Configurable data width and depth, with two write ports and per-byte write enables.
- Optional hardwired zero register and optional same-cycle write-to-read forwarding.
- Sits in the datapath between decode (read addresses) and writeback. Port 0 is the main ALU writeback; port 1 is the load/late writeback.

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8
ADDR_W, 5, address width; depth = 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary storage
BYPASS, 0, 1 = read ports forward same-cycle write data; 0 = reads return stored contents only

Ports:
clk  input  1  clock; all writes occur on the rising edge
reset  input  1  asynchronous, active-low reset
regRNum1  input  ADDR_W  read port 1 address
regRNum2  input  ADDR_W  read port 2 address
rData1  output  DATA_W  read port 1 data (combinational)
rData2  output  DATA_W  read port 2 data (combinational)
wReg0  input  ADDR_W  write port 0 address
data0  input  DATA_W  write port 0 data
RegWrite0  input  1  write port 0 enable
byteEn0  input  DATA_W/8  write port 0 byte-lane enables; bit i covers bits [8i+7:8i]
wReg1  input  ADDR_W  write port 1 address
data1  input  DATA_W  write port 1 data
RegWrite1  input  1  write port 1 enable
byteEn1  input  DATA_W/8  write port 1 byte-lane enables

Behaviour:
- Reset:
  - reset low clears every register to 0 immediately, independent of clk.
  - While reset is low, writes are blocked, and rData1/rData2 = 0 for every address (BYPASS forwarding is suppressed).
  - Reset released mid-cycle: the first write is taken at the next rising edge with reset high.
- Writes:
  - On the rising edge with reset high, lane i of reg[wRegN] takes dataN lane i when RegWriteN=1 and byteEnN[i]=1.
  - Unenabled lanes hold their value.
  - RegWriteN=1 with byteEnN=0 is a no-op.
- Dual-write collision (wReg0 == wReg1, both enabled):
  - Resolved per lane.
  - A lane enabled on both ports takes port 1.
  - A lane enabled on one port only takes that port.
  - Different addresses: both writes complete in the same edge.
- ZERO_REG=1:
  - Writes to address 0 are discarded on both ports, all lanes.
  - Reads of address 0 return 0 regardless of BYPASS.
- Reads:
  - Purely combinational from the addresses; zero-cycle latency.
  - No read enable.
  - Both read ports may address the same register.
- BYPASS=0: a read of an address being written returns the old value until the edge, and the new value after it.
- BYPASS=1:
  - Per lane, rDataK returns the value the register will hold after the coming edge.
  - This uses the same per-lane merge and port-1 priority as the write logic.
  - Lanes not being written return stored contents.
  - Forwarding is combinational from the write inputs (wReg/data/RegWrite/byteEn).
- Width rules:
  - DATA_W not a multiple of 8 is illegal; elaboration must fail via a generate-time check.
  - Addresses wrap naturally within 2**ADDR_W; no out-of-range condition exists.
- X-handling: a disabled port's address and data are don't-care and must not affect state or read data.

Test Plan:
- Reset/clear: fill all 32 regs with k*10 via port 0 (byteEn0=4'hF), pulse reset low for 3 ns between clock edges -> all reads return 0 immediately, without waiting for an edge. With reset held low, RegWrite0=1 for one edge -> no register changes.
- Basic write/readback: write reg k = k*10 for k=0..31 on port 0 (ZERO_REG=1), read pairs (k, k+1) -> reg[0]=0, reg[k]=k*10 for k>=1. Repeat with ZERO_REG=0 -> reg[0]=0 because 0*10=0. Then write reg0=0x55 -> reads 0x55 with ZERO_REG=0, 0 with ZERO_REG=1.
- Byte enables: reg5=0x11223344, then port 0 writes 0xAABBCCDD to reg5 with byteEn0=4'b0101 -> reg5=0x11BB33DD. byteEn0=0 with RegWrite0=1 -> unchanged.
- Dual-write collision: reg9=0. Same edge: port 0 writes 0x01010101 to reg9 with byteEn0=4'b0011; port 1 writes 0x02020202 to reg9 with byteEn1=4'b0110 -> reg9=0x00020201. Separate addresses reg3 and reg4 in the same edge -> both written.
- Forwarding: reg7=0x100. Drive a write of 0x200 to reg7 with rData1 addressing reg7, sampled before the edge -> 0x100 with BYPASS=0, 0x200 with BYPASS=1. Repeat with byteEn=4'b0001 -> BYPASS=1 reads 0x100 (low-byte merge of 0x00 into 0x100).
- Parametrisation: DATA_W=16, ADDR_W=3, write regs 0..7 with 0xF0F0+k, read back -> correct values. Write to address 8 aliases to address 0 under the 3-bit address -> reg0 written when ZERO_REG=0.
